demux_fifo: RTL and testbench

- Parametrised successor to the plain registered demux: routes one valid/ready input stream to NUMOUT output channels.
- Each channel has its own DEPTH-entry first-word-fall-through FIFO, so a stalled consumer holds only its own channel, not the others.
- Adds a broadcast mode, per-channel fill levels and an out-of-range select error.
- Sits between a shared producer (e.g. packet parser) and NUMOUT independent consumers.

---
 rtl/demux_fifo_chan.sv | 56 +++++
 rtl/demux_fifo.sv | 68 ++++++
 tb/tb_demux_fifo.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_fifo_chan.sv
// One output channel of demux_fifo: synchronous first-word-fall-through FIFO.
// Head entry is presented combinationally; count is the registered occupancy.
module demux_fifo_chan #(
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 4,
  localparam int PTRW   = $clog2(DEPTH),
  localparam int CNTW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              pop,
  output logic [DWIDTH-1:0] rdata,
  output logic              valid,
  output logic              full,
  output logic [CNTW-1:0]   count
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]   wptr;
  logic [PTRW-1:0]   rptr;
  logic              do_push;
  logic              do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  // Head is forced to zero while empty so the output is clean out of reset.
  assign rdata = valid ? mem[rptr] : '0;

  // NOTE: the storage array has no reset; stale words are unreachable once
  // the pointers and count are cleared, and a reset would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_fifo.sv
// Routes one valid/ready stream to NUMOUT independently buffered channels,
// with broadcast, per-channel fill levels and an out-of-range select pulse.
module demux_fifo #(
  parameter  int NUMOUT = 16,
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 4,
  localparam int SELW   = $clog2(NUMOUT),
  localparam int CNTW   = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     din_v,
  input  logic [SELW-1:0]          din_sel,
  input  logic                     din_bcast,
  output logic                     din_rdy,
  output logic [NUMOUT*DWIDTH-1:0] dout_vec,
  output logic [NUMOUT-1:0]        dout_vec_v,
  input  logic [NUMOUT-1:0]        dout_vec_rdy,
  output logic [NUMOUT*CNTW-1:0]   fill_vec,
  output logic                     err_sel
);

  localparam logic [SELW:0] NUM_L = (SELW + 1)'(NUMOUT);

  logic [NUMOUT-1:0] full_vec;
  logic [NUMOUT-1:0] sel_hit;
  logic [NUMOUT-1:0] push_vec;
  logic              sel_ok;
  logic              sel_free;
  logic              all_free;
  logic              xfer;

  assign sel_ok   = ({1'b0, din_sel} < NUM_L);
  assign sel_free = |(sel_hit & ~full_vec);
  assign all_free = ~|full_vec;

  // Ready looks only at registered fullness: a pop in the same cycle never
  // frees a slot, which keeps dout_vec_rdy out of the din_rdy timing path.
  assign din_rdy = rst_n && (din_bcast ? all_free : (sel_free || !sel_ok));
  assign xfer    = din_v && din_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) err_sel <= 1'b0;
    else        err_sel <= xfer && !din_bcast && !sel_ok;
  end

  for (genvar g = 0; g < NUMOUT; g++) begin : g_chan
    assign sel_hit[g]  = (din_sel == SELW'(g));
    assign push_vec[g] = xfer && (din_bcast || sel_hit[g]);

    demux_fifo_chan #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_vec[g]),
      .wdata (din),
      .pop   (dout_vec_rdy[g]),
      .rdata (dout_vec[g*DWIDTH +: DWIDTH]),
      .valid (dout_vec_v[g]),
      .full  (full_vec[g]),
      .count (fill_vec[g*CNTW +: CNTW])
    );
  end

endmodule

// File: tb/tb_demux_fifo.sv
// Scoreboard bench for demux_fifo: a 16-channel instance with a pop monitor,
// plus a 5-channel instance for the out-of-range select path.
module tb_demux_fifo;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   din;
  logic         din_v;
  logic [3:0]   din_sel;
  logic         din_bcast;
  logic         din_rdy;
  logic [127:0] dout_vec;
  logic [15:0]  dout_vec_v;
  logic [15:0]  dout_vec_rdy;
  logic [15:0]  rdy_nxt;
  logic [47:0]  fill_vec;
  logic         err_sel;

  logic         din_v5;
  logic [2:0]   din_sel5;
  logic         din_rdy5;
  logic [39:0]  dout_vec5;
  logic [4:0]   dout_vec_v5;
  logic [14:0]  fill_vec5;
  logic         err_sel5;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q [16][$];

  always #5 clk = ~clk;

  demux_fifo #(.NUMOUT(16), .DWIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_v        (din_v),
    .din_sel      (din_sel),
    .din_bcast    (din_bcast),
    .din_rdy      (din_rdy),
    .dout_vec     (dout_vec),
    .dout_vec_v   (dout_vec_v),
    .dout_vec_rdy (dout_vec_rdy),
    .fill_vec     (fill_vec),
    .err_sel      (err_sel)
  );

  demux_fifo #(.NUMOUT(5), .DWIDTH(8), .DEPTH(4)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_v        (din_v5),
    .din_sel      (din_sel5),
    .din_bcast    (din_bcast),
    .din_rdy      (din_rdy5),
    .dout_vec     (dout_vec5),
    .dout_vec_v   (dout_vec_v5),
    .dout_vec_rdy (5'b11111),
    .fill_vec     (fill_vec5),
    .err_sel      (err_sel5)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] fill(input int i);
    return fill_vec[i*3 +: 3];
  endfunction

  // Inputs change 1 time unit after the edge; everything is sampled on negedge.
  task automatic cyc(input logic v, input logic [7:0] d, input int sel, input logic bc);
    @(posedge clk);
    #1;
    din_v        = v;
    din          = d;
    din_sel      = 4'(sel);
    din_bcast    = bc;
    din_v5       = 1'b0;
    dout_vec_rdy = rdy_nxt;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input int sel, input logic bc, input logic exp_rdy);
    cyc(1'b1, d, sel, bc);
    check($sformatf("din_rdy sel=%0d bc=%0b d=%0h", sel, bc, d), din_rdy, exp_rdy);
    if (exp_rdy) begin
      if (bc) for (int i = 0; i < 16; i++) q[i].push_back(d);
      else    q[sel].push_back(d);
    end
  endtask

  task automatic cyc5(input logic v, input logic [7:0] d, input logic [2:0] sel);
    @(posedge clk);
    #1;
    din_v    = 1'b0;
    din_v5   = v;
    din      = d;
    din_sel5 = sel;
    din_bcast = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every pop the DUT performs must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 16; i++) begin
        if (dout_vec_v[i] && dout_vec_rdy[i]) begin
          check($sformatf("ch%0d pop expected", i), q[i].size() > 0, 1'b1);
          if (q[i].size() > 0) begin
            check($sformatf("ch%0d data", i), dout_vec[i*8 +: 8], q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; din = '0; din_v = 1'b0; din_sel = '0; din_bcast = 1'b0;
    din_v5 = 1'b0; din_sel5 = '0;
    rdy_nxt = 16'hFFFF; dout_vec_rdy = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("reset dout_vec_v", dout_vec_v, 16'h0);
    check("reset fill_vec", fill_vec, 48'h0);
    check("reset err_sel", err_sel, 1'b0);
    check("reset dout_vec", dout_vec, 128'h0);
    check("reset din_rdy", din_rdy, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: single unicast, one-cycle latency, drains next cycle
    send(8'h11, 3, 1'b0, 1'b1);
    idle();
    check("t1 valid", dout_vec_v, 16'h0008);
    check("t1 fill3", fill(3), 3'd1);
    idle();
    check("t1 fill3 drained", fill(3), 3'd0);
    check("t1 valid drained", dout_vec_v, 16'h0000);

    // 2: stalled channel 5 fills, others unaffected, order kept on release
    rdy_nxt[5] = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), 5, 1'b0, 1'b1);
    send(8'hA4, 5, 1'b0, 1'b0);
    check("t2 fill5 full", fill(5), 3'd4);
    send(8'h33, 6, 1'b0, 1'b1);
    rdy_nxt[5] = 1'b1;
    send(8'hA4, 5, 1'b0, 1'b0);
    send(8'hA4, 5, 1'b0, 1'b1);
    repeat (6) idle();
    check("t2 fill5 drained", fill(5), 3'd0);

    // 3: broadcast, then broadcast blocked by one full channel
    send(8'h5A, 0, 1'b1, 1'b1);
    idle();
    check("t3 bcast valid", dout_vec_v, 16'hFFFF);
    check("t3 bcast fill", fill_vec, {16{3'd1}});
    rdy_nxt[7] = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) send(8'h70 + 8'(k), 7, 1'b0, 1'b1);
    send(8'hB5, 0, 1'b1, 1'b0);
    idle();
    check("t3 blocked bcast valid", dout_vec_v, 16'h0080);
    check("t3 blocked bcast fill7", fill(7), 3'd4);
    rdy_nxt[7] = 1'b1;
    repeat (5) idle();

    // 4: simultaneous push/pop keeps count; at full the push is refused
    rdy_nxt[2] = 1'b0;
    idle();
    send(8'hC0, 2, 1'b0, 1'b1);
    send(8'hC1, 2, 1'b0, 1'b1);
    idle();
    check("t4 fill2 two", fill(2), 3'd2);
    rdy_nxt[2] = 1'b1;
    send(8'hC2, 2, 1'b0, 1'b1);
    rdy_nxt[2] = 1'b0;
    idle();
    check("t4 fill2 push+pop", fill(2), 3'd2);
    send(8'hC3, 2, 1'b0, 1'b1);
    send(8'hC4, 2, 1'b0, 1'b1);
    idle();
    check("t4 fill2 full", fill(2), 3'd4);
    rdy_nxt[2] = 1'b1;
    send(8'hC5, 2, 1'b0, 1'b0);
    idle();
    check("t4 fill2 after refused push", fill(2), 3'd3);
    repeat (4) idle();

    // 5: out-of-range select on the 5-channel build
    cyc5(1'b1, 8'h77, 3'd6);
    check("t5 din_rdy5 sel6", din_rdy5, 1'b1);
    check("t5 err_sel5 before", err_sel5, 1'b0);
    cyc5(1'b0, 8'h00, 3'd0);
    check("t5 err_sel5 pulse", err_sel5, 1'b1);
    check("t5 valid5 none", dout_vec_v5, 5'h00);
    cyc5(1'b0, 8'h00, 3'd0);
    check("t5 err_sel5 cleared", err_sel5, 1'b0);
    cyc5(1'b1, 8'h44, 3'd4);
    check("t5 din_rdy5 sel4", din_rdy5, 1'b1);
    cyc5(1'b0, 8'h00, 3'd0);
    check("t5 valid5 sel4", dout_vec_v5, 5'h10);
    check("t5 data5 sel4", dout_vec5[39:32], 8'h44);
    check("t5 err_sel5 sel4", err_sel5, 1'b0);

    // 6: reset mid-operation discards stored data
    rdy_nxt = 16'hFFEC;
    idle();
    send(8'hD0, 0, 1'b0, 1'b1);
    send(8'hD1, 1, 1'b0, 1'b1);
    send(8'hD4, 4, 1'b0, 1'b1);
    idle();
    check("t6 loaded valid", dout_vec_v, 16'h0013);
    @(posedge clk); #1;
    rst_n = 1'b0; din_v = 1'b1; din = 8'hEE; din_sel = 4'd0; din_bcast = 1'b0;
    for (int i = 0; i < 16; i++) q[i].delete();
    @(negedge clk);
    check("t6 din_rdy in reset", din_rdy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; din_v = 1'b0; rdy_nxt = 16'hFFFF; dout_vec_rdy = 16'hFFFF;
    @(negedge clk);
    check("t6 valid after reset", dout_vec_v, 16'h0);
    check("t6 fill after reset", fill_vec, 48'h0);
    check("t6 dout after reset", dout_vec, 128'h0);
    send(8'hE1, 0, 1'b0, 1'b1);
    idle();
    check("t6 first push valid", dout_vec_v, 16'h0001);

    repeat (6) idle();
    for (int i = 0; i < 16; i++) check($sformatf("ch%0d scoreboard empty", i), q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
